// File: rtl/sub_fp_pipe.sv
// sub_fp_pipe: three-stage pipelined fixed-point A-B with truncation, saturation and a saturation counter
module sub_fp_pipe #(
    parameter int NB_IN_A  = 16,
    parameter int NBF_IN_A = 14,
    parameter int NB_IN_B  = 12,
    parameter int NBF_IN_B = 11,
    parameter int NB_OUT   = 11,
    parameter int NBF_OUT  = 10,
    localparam int NBI_A  = NB_IN_A - NBF_IN_A,
    localparam int NBI_B  = NB_IN_B - NBF_IN_B,
    localparam int NBI_FR = (NBI_A > NBI_B ? NBI_A : NBI_B) + 1,
    localparam int NBF_FR = NBF_IN_A > NBF_IN_B ? NBF_IN_A : NBF_IN_B,
    localparam int NB_FR  = NBI_FR + NBF_FR
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB_IN_A-1:0] i_A,
    input  logic [NB_IN_B-1:0] i_B,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [NB_FR-1:0]  o_diff_fr,
    output logic [NB_OUT-1:0] o_diff,
    output logic              o_sat,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_clear_cnt,
    output logic [7:0]        o_sat_count
);
    localparam int NBI_OUT = NB_OUT - NBF_OUT;
    localparam int NB_TR   = NB_FR - (NBF_FR - NBF_OUT);
    localparam int NSAT    = NBI_FR - NBI_OUT + 1;

    logic [NB_FR-1:0]  a_ext, b_ext, s1_a, s1_b, s2_d;
    logic [NB_TR-1:0]  tr;
    logic [NSAT-1:0]   top;
    logic [NB_OUT-1:0] q;
    logic              v1, v2, en, fit;

    assign en      = i_ready | ~o_valid;
    assign o_ready = en;
    assign a_ext   = NB_FR'({{(NBI_FR-NBI_A){i_A[NB_IN_A-1]}}, i_A}) << (NBF_FR - NBF_IN_A);
    assign b_ext   = NB_FR'({{(NBI_FR-NBI_B){i_B[NB_IN_B-1]}}, i_B}) << (NBF_FR - NBF_IN_B);
    assign tr      = s2_d[NB_FR-1 -: NB_TR];
    assign top     = tr[NB_TR-1 -: NSAT];
    assign fit     = &top | ~|top;
    assign q       = fit ? tr[NB_OUT-1:0] : {tr[NB_TR-1], {(NB_OUT-1){~tr[NB_TR-1]}}};

    // three pipeline stages that advance together only when the output side can move
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            o_valid   <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_d      <= '0;
            o_diff_fr <= '0;
            o_diff    <= '0;
            o_sat     <= 1'b0;
        end else if (en) begin
            v1        <= i_valid;
            s1_a      <= a_ext;
            s1_b      <= b_ext;
            v2        <= v1;
            s2_d      <= s1_a - s1_b;
            o_valid   <= v2;
            o_diff_fr <= s2_d;
            o_diff    <= q;
            o_sat     <= ~fit;
        end
    end

    // saturating count of accepted saturated beats; clear wins over increment
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            o_sat_count <= '0;
        else if (i_clear_cnt)
            o_sat_count <= '0;
        else if (o_valid & i_ready & o_sat & ~&o_sat_count)
            o_sat_count <= o_sat_count + 8'd1;
    end
endmodule

// File: tb/tb_sub_fp_pipe.sv
// tb_sub_fp_pipe: directed self-checking bench for sub_fp_pipe at default parameters
module tb_sub_fp_pipe;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] i_A = '0;
    logic [11:0] i_B = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [16:0] o_diff_fr;
    logic [10:0] o_diff;
    logic        o_sat;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        i_clear_cnt = 1'b0;
    logic [7:0]  o_sat_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [15:0] a;
        logic [11:0] b;
        logic [16:0] fr;
        logic [10:0] d;
        logic        s;
    } vec_t;
    vec_t vt [8];

    sub_fp_pipe dut (
        .i_clock(clk), .i_reset(i_reset), .i_A(i_A), .i_B(i_B), .i_valid(i_valid),
        .o_ready(o_ready), .o_diff_fr(o_diff_fr), .o_diff(o_diff), .o_sat(o_sat),
        .o_valid(o_valid), .i_ready(i_ready), .i_clear_cnt(i_clear_cnt), .o_sat_count(o_sat_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_handshake: o_valid=%b o_ready=%b required 0 1", o_valid, o_ready);
        end
        n_cmp++;
        if (o_diff_fr !== 17'h0 || o_diff !== 11'h0 || o_sat !== 1'b0 || o_sat_count !== 8'h0) begin
            n_err++;
            $display("FAIL reset_data: fr=%h d=%h sat=%b cnt=%0d required all zero", o_diff_fr, o_diff, o_sat, o_sat_count);
        end
        step;
        i_reset = 1'b0;
        step;
    endtask

    task automatic test_vectors;
        for (int i = 0; i < 8; i++) begin
            i_A = vt[i].a;
            i_B = vt[i].b;
            i_valid = 1'b1;
            step;
            i_valid = 1'b0;
            step;
            step;
            #1;
            n_cmp++;
            if (o_valid !== 1'b1 || o_diff_fr !== vt[i].fr || o_diff !== vt[i].d || o_sat !== vt[i].s) begin
                n_err++;
                $display("FAIL vec%0d: valid=%b fr=%h d=%h sat=%b required 1 %h %h %b",
                         i, o_valid, o_diff_fr, o_diff, o_sat, vt[i].fr, vt[i].d, vt[i].s);
            end
            exp_cnt += int'(vt[i].s);
            step;
            n_cmp++;
            if (o_sat_count !== 8'(exp_cnt) || o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL vec%0d_count: cnt=%0d valid=%b required %0d 0", i, o_sat_count, o_valid, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int recv = 0;
        int extra = 0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            i_valid = sent < 5;
            i_A = vt[sent < 5 ? sent : 0].a;
            i_B = vt[sent < 5 ? sent : 0].b;
            i_ready = !(cyc >= 4 && cyc < 7);
            #1;
            if (cyc >= 4 && cyc < 7) begin
                n_cmp++;
                if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_stall%0d: o_ready=%b o_valid=%b required 0 1", cyc, o_ready, o_valid);
                end
            end
            if (o_valid && i_ready) begin
                n_cmp++;
                if (o_diff !== vt[recv].d || o_diff_fr !== vt[recv].fr) begin
                    n_err++;
                    $display("FAIL b2b_out%0d: fr=%h d=%h required %h %h", recv, o_diff_fr, o_diff, vt[recv].fr, vt[recv].d);
                end
                recv++;
            end
            if (i_valid && o_ready) sent++;
            step;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_cmp++;
        if (recv != 5 || sent != 5) begin
            n_err++;
            $display("FAIL b2b_count: sent=%0d recv=%0d required 5 5", sent, recv);
        end
        for (int k = 0; k < 4; k++) begin
            if (o_valid) extra++;
            step;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL b2b_dup: extra beats=%0d required 0", extra);
        end
    endtask

    task automatic test_sat_count;
        i_A = 16'h6000;
        i_B = 12'h800;
        i_valid = 1'b1;
        repeat (300) step;
        i_valid = 1'b0;
        repeat (5) step;
        n_cmp++;
        if (o_sat_count !== 8'd255) begin
            n_err++;
            $display("FAIL satcnt_max: cnt=%0d required 255", o_sat_count);
        end
        i_valid = 1'b1;
        step;
        i_valid = 1'b0;
        step;
        step;
        i_clear_cnt = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 1'b1 || o_sat !== 1'b1) begin
            n_err++;
            $display("FAIL satcnt_setup: valid=%b sat=%b required 1 1", o_valid, o_sat);
        end
        step;
        i_clear_cnt = 1'b0;
        n_cmp++;
        if (o_sat_count !== 8'd0) begin
            n_err++;
            $display("FAIL satcnt_clear_prio: cnt=%0d required 0", o_sat_count);
        end
        i_valid = 1'b1;
        step;
        i_valid = 1'b0;
        repeat (3) step;
        n_cmp++;
        if (o_sat_count !== 8'd1) begin
            n_err++;
            $display("FAIL satcnt_after_clear: cnt=%0d required 1", o_sat_count);
        end
        i_clear_cnt = 1'b1;
        step;
        i_clear_cnt = 1'b0;
        n_cmp++;
        if (o_sat_count !== 8'd0) begin
            n_err++;
            $display("FAIL satcnt_clear: cnt=%0d required 0", o_sat_count);
        end
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        i_A = 16'h6000;
        i_B = 12'h800;
        i_valid = 1'b1;
        repeat (5) step;
        #2;
        n_cmp++;
        if (o_valid !== 1'b1 || o_sat_count !== 8'd2) begin
            n_err++;
            $display("FAIL midrst_pre: valid=%b cnt=%0d required 1 2", o_valid, o_sat_count);
        end
        i_reset = 1'b1;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sat_count !== 8'd0 || o_diff !== 11'h0 || o_sat !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: valid=%b ready=%b cnt=%0d d=%h sat=%b required 0 1 0 000 0",
                     o_valid, o_ready, o_sat_count, o_diff, o_sat);
        end
        i_valid = 1'b0;
        step;
        i_reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (o_valid) stale++;
            step;
        end
        n_cmp++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL midrst_stale: stale beats=%0d required 0", stale);
        end
    endtask

    initial begin
        vt[0] = '{16'h2000, 12'h200, 17'h01000, 11'h100, 1'b0};
        vt[1] = '{16'h6000, 12'h800, 17'h0A000, 11'h3FF, 1'b1};
        vt[2] = '{16'h8000, 12'h400, 17'h16000, 11'h400, 1'b1};
        vt[3] = '{16'h0001, 12'h000, 17'h00001, 11'h000, 1'b0};
        vt[4] = '{16'hFFFF, 12'h000, 17'h1FFFF, 11'h7FF, 1'b0};
        vt[5] = '{16'h0000, 12'h7FF, 17'h1C008, 11'h400, 1'b0};
        vt[6] = '{16'h4000, 12'h000, 17'h04000, 11'h3FF, 1'b1};
        vt[7] = '{16'h3FF0, 12'h000, 17'h03FF0, 11'h3FF, 1'b0};
        test_reset;
        test_vectors;
        test_back_to_back;
        test_sat_count;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
